clocks_period_ctrl: RTL and testbench
=====================================

// Module: clocks_period_ctrl
// PURPOSE
//   Configuration sequencer in front of the clocks block (four period-driven
//   clock generators A-D). Buffers register-bus period writes in shadow
//   registers and commits them atomically: all active periods update on the
//   same cycle, then a timed reset pulse restarts all four generators phase-aligned.
// PARAMETERS
//   PERIOD_W    32  width of each period value
//   MIN_PERIOD  2   commit-time floor; smaller shadow values are clamped to this
//   RST_LEN     2   cycles clocks_reset_o is held high per commit (>=1)
//   AUTO_DELAY  4   quiet cycles before auto-commit (CLOCKS_AUTO_COMMIT_EN only)
// PORTS
//   clk_i         in   1         system clock
//   reset_n_i     in   1         asynchronous reset, active low
//   wr_addr_i     in   2         shadow select: 0=A 1=B 2=C 3=D
//   wr_data_i     in   PERIOD_W  period value
//   wr_stb_i      in   1         one-cycle write strobe
//   commit_i      in   1         one-cycle commit request
//   period_a_o    out  PERIOD_W  active period to clocks CLOCKA_PERIOD (B,C,D alike)
//   clocks_reset_o out 1         reset to clocks block (active high)
//   busy_o        out  1         high whenever FSM is not IDLE
//   pending_o     out  4         per-channel shadow-differs-from-committed flags
//   commit_cnt_o  out  16        number of completed commits, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (async, reset_n_i=0): shadows and active periods = MIN_PERIOD,
//     pending_o=0, clocks_reset_o=1 (generators held), busy_o=1, commit_cnt_o=0,
//     commit latch cleared; FSM=RESET with counter=RST_LEN, so after release
//     clocks_reset_o stays high RST_LEN cycles then drops; this does not count.
//   Write: wr_stb_i registers wr_data_i into shadow[wr_addr_i] and sets
//     pending_o[wr_addr_i] next cycle. Legal in every state; never touches
//     active outputs directly. Same-cycle rewrite of same channel: last wins.
//   FSM states: IDLE, LOAD, RESET.
//     IDLE : commit_i or commit latch set -> LOAD (latch cleared).
//     LOAD : one cycle; each active period <= max(shadow, MIN_PERIOD) for all
//            four channels (channels without pending reload same value);
//            pending_o cleared except bits written in this same cycle -> RESET.
//     RESET: clocks_reset_o=1 for exactly RST_LEN cycles -> IDLE;
//            commit_cnt_o increments on the RESET->IDLE transition.
//   Latency: commit_i at cycle N -> periods change N+2, clocks_reset_o high
//     N+2..N+1+RST_LEN, busy_o low at N+2+RST_LEN.
//   clocks_reset_o and period outputs are registered; periods never change
//     outside LOAD, so the clocks block only sees new values under reset.
//   commit_i while busy: latched (one deep, extra requests merge); a second
//     commit runs immediately after the current one returns to IDLE.
//   commit_i with pending_o=0: still performs a full restart (re-align).
//   Write arriving in same cycle as LOAD: shadow updated, value NOT committed,
//     pending bit stays set for next commit.
// CONFIGURATION
//   CLOCKS_AUTO_COMMIT_EN defined: a quiet counter reloads to AUTO_DELAY on
//     every wr_stb_i; while IDLE with pending_o!=0 it counts down, and at 0
//     issues an internal commit (ORed with commit_i). Burst writes coalesce
//     into one restart. Counter frozen while busy_o=1.
//   Undefined: no counter logic; commits only via commit_i.
// TESTING
//   1 Reset release: periods=2, clocks_reset_o high 2 cycles after release, then 0;
//     commit_cnt_o=0.
//   2 Write A=10,C=7, commit_i -> pending_o=0101 then 0000; period_a_o=10,
//     period_c_o=7 on same cycle; clocks_reset_o high 2 cycles; commit_cnt_o=1.
//   3 Write B=0, commit -> period_b_o=2 (clamped); write D=1 -> D commits as 2.
//   4 commit_i during RESET with write A=20 in same window -> exactly one extra
//     commit follows; period_a_o=20; commit_cnt_o advances by 2 total.
//   5 Write D=33 in LOAD cycle -> period_d_o unchanged, pending_o[3]=1 after.
//   6 (CLOCKS_AUTO_COMMIT_EN) writes A=5,B=6,C=8 one per 2 cycles -> single
//     restart 4 cycles after last write; commit_cnt_o+1; without macro: no commit.

Source files
------------

// File: rtl/clocks_period_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clocks_period_ctrl
// Purpose  : Configuration sequencer in front of the four-generator clocks
//            block. Register-bus period writes land in shadow registers. A
//            commit copies all four shadows into the active period outputs on
//            the same cycle, clamping each one to MIN_PERIOD. It then holds
//            clocks_reset_o high for RST_LEN cycles so that all generators
//            restart phase-aligned on the new periods.
// Ports    : clk_i          system clock
//            reset_n_i      asynchronous reset, active low
//            wr_addr_i      shadow select (0=A 1=B 2=C 3=D)
//            wr_data_i      period value to write
//            wr_stb_i       one-cycle write strobe
//            commit_i       one-cycle commit request
//            period_[a-d]_o active periods driven to the clocks block
//            clocks_reset_o generator reset (active high, registered)
//            busy_o         high whenever the sequencer is not idle
//            pending_o      per-channel "shadow differs from committed" flags
//            commit_cnt_o   completed commits, wraps 0xFFFF -> 0
// Options  : CLOCKS_AUTO_COMMIT_EN - when defined, a quiet-time counter issues
//            an internal commit AUTO_DELAY idle cycles after the last write.
// Revision : 1.0 - initial release
// ============================================================================
module clocks_period_ctrl #(
  parameter int PERIOD_W   = 32,
  parameter int MIN_PERIOD = 2,
  parameter int RST_LEN    = 2,
  parameter int AUTO_DELAY = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [1:0]          wr_addr_i,
  input  logic [PERIOD_W-1:0] wr_data_i,
  input  logic                wr_stb_i,
  input  logic                commit_i,
  output logic [PERIOD_W-1:0] period_a_o,
  output logic [PERIOD_W-1:0] period_b_o,
  output logic [PERIOD_W-1:0] period_c_o,
  output logic [PERIOD_W-1:0] period_d_o,
  output logic                clocks_reset_o,
  output logic                busy_o,
  output logic [3:0]          pending_o,
  output logic [15:0]         commit_cnt_o
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_reset = 2'd2;

  localparam int                  c_cnt_w = (RST_LEN < 2) ? 1 : $clog2(RST_LEN + 1);
  localparam logic [PERIOD_W-1:0] c_min   = PERIOD_W'(MIN_PERIOD);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_cnt_w-1:0] r_rst_cnt;
  logic               r_clocks_reset;
  logic               r_latch;      // commit requested while busy (one deep)
  logic               r_boot;       // current RESET phase comes from power-up
  logic [15:0]        r_commit_cnt;
  logic               w_auto;
  logic               w_commit_req;
  logic               w_load;
  logic               w_done;

  assign w_commit_req = commit_i | r_latch | w_auto;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state        <= c_st_reset;
      r_rst_cnt      <= c_cnt_w'(RST_LEN);
      r_clocks_reset <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      // Registered copy of "next state is RESET" so the pulse lines up with
      // the cycle on which the new periods first appear.
      r_clocks_reset <= (w_state_nxt == c_st_reset);
      if (r_state == c_st_load) begin
        r_rst_cnt <= c_cnt_w'(RST_LEN);
      end else if (r_state == c_st_reset) begin
        r_rst_cnt <= r_rst_cnt - c_cnt_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_commit_req) w_state_nxt = c_st_load;
      c_st_load:  w_state_nxt = c_st_reset;
      c_st_reset: if (r_rst_cnt == c_cnt_w'(1)) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o = (r_state != c_st_idle);
    w_load = (r_state == c_st_load);
    w_done = (r_state == c_st_reset) && (w_state_nxt == c_st_idle);
  end

  // Commit latch, boot marker and completed-commit counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_latch      <= 1'b0;
      r_boot       <= 1'b1;
      r_commit_cnt <= 16'd0;
    end else begin
      // Any request seen in IDLE is consumed by the move to LOAD, so the
      // latch only needs to remember requests that arrive while busy.
      if (r_state == c_st_idle) begin
        r_latch <= 1'b0;
      end else if (commit_i) begin
        r_latch <= 1'b1;
      end
      if (w_done) begin
        r_boot <= 1'b0;
        if (!r_boot) begin
          r_commit_cnt <= r_commit_cnt + 16'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel shadow / active / pending registers
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_chan
    localparam logic [1:0] c_idx = 2'(i);
    logic [PERIOD_W-1:0] r_shadow;
    logic [PERIOD_W-1:0] r_active;
    logic                r_pend;
    logic                w_hit;

    assign w_hit = wr_stb_i && (wr_addr_i == c_idx);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_shadow <= c_min;
        r_active <= c_min;
        r_pend   <= 1'b0;
      end else begin
        if (w_hit) begin
          r_shadow <= wr_data_i;
        end
        // LOAD samples the shadow as it was before this cycle's write, so a
        // write landing on LOAD stays pending for the next commit.
        if (w_load) begin
          r_active <= (r_shadow < c_min) ? c_min : r_shadow;
        end
        if (w_hit) begin
          r_pend <= 1'b1;
        end else if (w_load) begin
          r_pend <= 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional auto-commit after a quiet period
  // --------------------------------------------------------------------------
`ifdef CLOCKS_AUTO_COMMIT_EN
  localparam int c_quiet_w = (AUTO_DELAY < 2) ? 1 : $clog2(AUTO_DELAY + 1);
  logic [c_quiet_w-1:0] r_quiet;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_quiet <= c_quiet_w'(AUTO_DELAY);
    end else if (wr_stb_i) begin
      r_quiet <= c_quiet_w'(AUTO_DELAY);
    end else if ((r_state == c_st_idle) && (|pending_o) && (r_quiet != '0)) begin
      r_quiet <= r_quiet - c_quiet_w'(1);
    end
  end

  assign w_auto = (r_state == c_st_idle) && (|pending_o) && (r_quiet == '0);
`else
  // No quiet counter in this build; the expression is constant false.
  assign w_auto = (AUTO_DELAY < 0);
`endif

  assign period_a_o     = g_chan[0].r_active;
  assign period_b_o     = g_chan[1].r_active;
  assign period_c_o     = g_chan[2].r_active;
  assign period_d_o     = g_chan[3].r_active;
  assign pending_o      = {g_chan[3].r_pend, g_chan[2].r_pend,
                           g_chan[1].r_pend, g_chan[0].r_pend};
  assign clocks_reset_o = r_clocks_reset;
  assign commit_cnt_o   = r_commit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clocks_period_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clocks_period_ctrl
// Purpose  : Self-checking bench for clocks_period_ctrl. A directed vector
//            table and hand sequences cover the commit flow, clamping, latched
//            commits, writes during LOAD and the quiet-time auto commit. A
//            random phase is then compared every cycle against a
//            cycle-countdown reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clocks_period_ctrl;

  localparam int MIN_P  = 2;
  localparam int RST_L  = 2;
  localparam int AUTO_D = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        wr_stb_i;
  logic        commit_i;
  logic [31:0] period_a_o, period_b_o, period_c_o, period_d_o;
  logic        clocks_reset_o;
  logic        busy_o;
  logic [3:0]  pending_o;
  logic [15:0] commit_cnt_o;

  clocks_period_ctrl dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .wr_addr_i      (wr_addr_i),
    .wr_data_i      (wr_data_i),
    .wr_stb_i       (wr_stb_i),
    .commit_i       (commit_i),
    .period_a_o     (period_a_o),
    .period_b_o     (period_b_o),
    .period_c_o     (period_c_o),
    .period_d_o     (period_d_o),
    .clocks_reset_o (clocks_reset_o),
    .busy_o         (busy_o),
    .pending_o      (pending_o),
    .commit_cnt_o   (commit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int restarts = 0;
  bit prev_rst = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the sequencer is described by how many cycles remain
  // until it is idle again (RST_L+1 at the LOAD cycle, 1..RST_L during reset).
  // --------------------------------------------------------------------------
  logic [31:0] m_shadow [4];
  logic [31:0] m_active [4];
  logic [3:0]  m_pend;
  logic [15:0] m_cnt;
  int          m_busy_left;
  bit          m_boot;
  bit          m_req;
  int          m_quiet;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = MIN_P;
      m_active[i] = MIN_P;
    end
    m_pend      = 4'b0000;
    m_cnt       = 16'd0;
    m_busy_left = RST_L;
    m_boot      = 1'b1;
    m_req       = 1'b0;
    m_quiet     = AUTO_D;
  endtask

  task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] d,
                            input logic cm);
    int   bl;
    logic [3:0] pend_old;
    bit   auto_c;
    bl       = m_busy_left;
    pend_old = m_pend;
    auto_c   = 1'b0;
`ifdef CLOCKS_AUTO_COMMIT_EN
    auto_c = (bl == 0) && (pend_old != 4'b0000) && (m_quiet == 0);
    if (wr) m_quiet = AUTO_D;
    else if (bl == 0 && pend_old != 4'b0000 && m_quiet > 0) m_quiet = m_quiet - 1;
`endif
    if (bl == RST_L + 1) begin
      for (int i = 0; i < 4; i++) m_active[i] = (m_shadow[i] < MIN_P) ? MIN_P : m_shadow[i];
      m_pend = 4'b0000;
    end
    if (wr) begin
      m_shadow[a] = d;
      m_pend[a]   = 1'b1;
    end
    if (bl == 0) begin
      if (cm || m_req || auto_c) begin
        m_busy_left = RST_L + 1;
        m_req       = 1'b0;
      end
    end else begin
      if (cm) m_req = 1'b1;
      if (bl == 1) begin
        if (!m_boot) m_cnt = m_cnt + 16'd1;
        m_boot = 1'b0;
      end
      m_busy_left = bl - 1;
    end
  endtask

  task automatic check_model();
    check("m_period_a", period_a_o, m_active[0]);
    check("m_period_b", period_b_o, m_active[1]);
    check("m_period_c", period_c_o, m_active[2]);
    check("m_period_d", period_d_o, m_active[3]);
    check("m_clocks_reset", clocks_reset_o, (m_busy_left >= 1) && (m_busy_left <= RST_L));
    check("m_busy", busy_o, m_busy_left > 0);
    check("m_pending", pending_o, m_pend);
    check("m_commit_cnt", commit_cnt_o, m_cnt);
  endtask

  // Drive one cycle's inputs (just after posedge), compare at the negedge.
  task automatic apply(input logic wr, input logic [1:0] a, input logic [31:0] d,
                       input logic cm);
    wr_stb_i  = wr;
    wr_addr_i = a;
    wr_data_i = d;
    commit_i  = cm;
    @(negedge clk_i);
    check_model();
    if (clocks_reset_o && !prev_rst) restarts++;
    prev_rst = clocks_reset_o;
  endtask

  // Close the cycle: clock edge, model update with the inputs just sampled.
  task automatic advance();
    @(posedge clk_i);
    model_step(wr_stb_i, wr_addr_i, wr_data_i, commit_i);
    #1;
    wr_stb_i = 1'b0;
    commit_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 2'd0, 32'd0, 1'b0);
      advance();
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table, one row per cycle starting at reset release
  // --------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic        cm;
    logic [31:0] ea, eb, ec, ed;
    logic        erst, ebusy;
    logic [3:0]  epend;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic wr, input logic [1:0] addr, input logic [31:0] data,
                              input logic cm, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] ec, input logic [31:0] ed, input logic erst,
                              input logic ebusy, input logic [3:0] epend, input logic [15:0] ecnt);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.cm = cm;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed;
    v.erst = erst; v.ebusy = ebusy; v.epend = epend; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    logic       wr;
    logic [1:0] a;
    logic [31:0] d;
    logic       cm;

    //              wr a  data cm   A   B  C  D  rst busy pend     cnt
    tbl[0]  = mk(0, 0,  0, 0,   2,  2, 2, 2,  1, 1, 4'b0000, 0); // reset tail
    tbl[1]  = mk(0, 0,  0, 0,   2,  2, 2, 2,  1, 1, 4'b0000, 0);
    tbl[2]  = mk(1, 0, 10, 0,   2,  2, 2, 2,  0, 0, 4'b0000, 0); // write A=10
    tbl[3]  = mk(1, 2,  7, 0,   2,  2, 2, 2,  0, 0, 4'b0001, 0); // write C=7
    tbl[4]  = mk(0, 0,  0, 1,   2,  2, 2, 2,  0, 0, 4'b0101, 0); // commit
    tbl[5]  = mk(0, 0,  0, 0,   2,  2, 2, 2,  0, 1, 4'b0101, 0); // LOAD
    tbl[6]  = mk(0, 0,  0, 0,  10,  2, 7, 2,  1, 1, 4'b0000, 0);
    tbl[7]  = mk(0, 0,  0, 0,  10,  2, 7, 2,  1, 1, 4'b0000, 0);
    tbl[8]  = mk(1, 1,  0, 0,  10,  2, 7, 2,  0, 0, 4'b0000, 1); // write B=0
    tbl[9]  = mk(0, 0,  0, 1,  10,  2, 7, 2,  0, 0, 4'b0010, 1); // commit
    tbl[10] = mk(0, 0,  0, 0,  10,  2, 7, 2,  0, 1, 4'b0010, 1);
    tbl[11] = mk(0, 0,  0, 0,  10,  2, 7, 2,  1, 1, 4'b0000, 1); // B clamped to 2
    tbl[12] = mk(1, 3,  1, 0,  10,  2, 7, 2,  1, 1, 4'b0000, 1); // write D=1 in RESET
    tbl[13] = mk(0, 0,  0, 1,  10,  2, 7, 2,  0, 0, 4'b1000, 2); // commit
    tbl[14] = mk(0, 0,  0, 0,  10,  2, 7, 2,  0, 1, 4'b1000, 2);
    tbl[15] = mk(0, 0,  0, 0,  10,  2, 7, 2,  1, 1, 4'b0000, 2); // D clamped to 2
    tbl[16] = mk(1, 0, 20, 1,  10,  2, 7, 2,  1, 1, 4'b0000, 2); // commit+write A in RESET
    tbl[17] = mk(0, 0,  0, 0,  10,  2, 7, 2,  0, 0, 4'b0001, 3); // one idle cycle
    tbl[18] = mk(1, 3, 33, 0,  10,  2, 7, 2,  0, 1, 4'b0001, 3); // write D=33 in LOAD
    tbl[19] = mk(0, 0,  0, 0,  20,  2, 7, 2,  1, 1, 4'b1000, 3);
    tbl[20] = mk(0, 0,  0, 0,  20,  2, 7, 2,  1, 1, 4'b1000, 3);
    tbl[21] = mk(0, 0,  0, 0,  20,  2, 7, 2,  0, 0, 4'b1000, 4);
    tbl[22] = mk(0, 0,  0, 0,  20,  2, 7, 2,  0, 0, 4'b1000, 4); // stays idle

    reset_n_i = 1'b0;
    wr_stb_i  = 1'b0;
    wr_addr_i = 2'd0;
    wr_data_i = 32'd0;
    commit_i  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_period_a", period_a_o, 32'd2);
    check("rst_period_d", period_d_o, 32'd2);
    check("rst_clocks_reset", clocks_reset_o, 1'b1);
    check("rst_busy", busy_o, 1'b1);
    check("rst_pending", pending_o, 4'b0000);
    check("rst_commit_cnt", commit_cnt_o, 16'd0);
    reset_n_i = 1'b1;

    for (int k = 0; k < 23; k++) begin
      apply(tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].cm);
      check($sformatf("tbl%0d_a", k), period_a_o, tbl[k].ea);
      check($sformatf("tbl%0d_b", k), period_b_o, tbl[k].eb);
      check($sformatf("tbl%0d_c", k), period_c_o, tbl[k].ec);
      check($sformatf("tbl%0d_d", k), period_d_o, tbl[k].ed);
      check($sformatf("tbl%0d_rst", k), clocks_reset_o, tbl[k].erst);
      check($sformatf("tbl%0d_busy", k), busy_o, tbl[k].ebusy);
      check($sformatf("tbl%0d_pend", k), pending_o, tbl[k].epend);
      check($sformatf("tbl%0d_cnt", k), commit_cnt_o, tbl[k].ecnt);
      advance();
    end

    // Spaced burst writes: coalesce into one auto restart, or none at all.
    restarts = 0;
    prev_rst = clocks_reset_o;
    apply(1'b1, 2'd0, 32'd5, 1'b0); advance();
    idle(1);
    apply(1'b1, 2'd1, 32'd6, 1'b0); advance();
    idle(1);
    apply(1'b1, 2'd2, 32'd8, 1'b0); advance();
    idle(14);
`ifdef CLOCKS_AUTO_COMMIT_EN
    check("auto_restarts", restarts, 1);
    check("auto_cnt", commit_cnt_o, 16'd5);
    check("auto_period_a", period_a_o, 32'd5);
    check("auto_period_b", period_b_o, 32'd6);
    check("auto_period_c", period_c_o, 32'd8);
    check("auto_period_d", period_d_o, 32'd33);
    check("auto_pending", pending_o, 4'b0000);
`else
    check("noauto_restarts", restarts, 0);
    check("noauto_cnt", commit_cnt_o, 16'd4);
    check("noauto_period_a", period_a_o, 32'd20);
    check("noauto_pending", pending_o, 4'b1111);
`endif

    // Asynchronous reset mid-cycle, then a commit with nothing pending.
    #2 reset_n_i = 1'b0;
    #1;
    check("arst_period_a", period_a_o, 32'd2);
    check("arst_clocks_reset", clocks_reset_o, 1'b1);
    check("arst_pending", pending_o, 4'b0000);
    check("arst_cnt", commit_cnt_o, 16'd0);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    model_reset();
    idle(3);
    restarts = 0;
    prev_rst = clocks_reset_o;
    apply(1'b0, 2'd0, 32'd0, 1'b1); advance();
    idle(5);
    check("realign_restarts", restarts, 1);
    check("realign_cnt", commit_cnt_o, 16'd1);
    check("realign_period_b", period_b_o, 32'd2);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      cm = ($urandom_range(0, 9) == 0);
      apply(wr, a, d, cm);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
